seg7_digit_decoder: RTL and testbench

- Registered BCD/hex-to-seven-segment decoder. Drives one digit of the board's HEX displays.
- One instance is placed per digit of the hh:mm:ss timer, which gives six instances per timer.
- It converts a 4-bit digit value into a 7-bit segment pattern, with lamp-test and blanking overrides.
- The output is registered, so all digits update on the same clock edge.

---
 rtl/seg7_digit_decoder.sv | 62 ++++++
 tb/tb_seg7_digit_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_digit_decoder.sv
// Registered hex/BCD to seven-segment decoder for one display digit.
// Lamp-test and blanking overrides; seg is driven only by a register.
module seg7_digit_decoder #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_EN     = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] seg
);

    localparam logic [6:0] ALL_ON_AH = 7'h7F;
    localparam logic [6:0] SEG_ON    = ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0] SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] w_pattern_ah;
    logic [6:0] w_pattern;
    logic [6:0] r_seg_q;

    // Active-high gfedcba patterns; polarity is applied afterwards.
    always_comb begin
        w_pattern_ah = 7'h00;
        case (digit)
            4'h0: w_pattern_ah = 7'h3F;
            4'h1: w_pattern_ah = 7'h06;
            4'h2: w_pattern_ah = 7'h5B;
            4'h3: w_pattern_ah = 7'h4F;
            4'h4: w_pattern_ah = 7'h66;
            4'h5: w_pattern_ah = 7'h6D;
            4'h6: w_pattern_ah = 7'h7D;
            4'h7: w_pattern_ah = 7'h07;
            4'h8: w_pattern_ah = ALL_ON_AH;
            4'h9: w_pattern_ah = 7'h6F;
            4'hA: w_pattern_ah = HEX_EN ? 7'h77 : 7'h00;
            4'hB: w_pattern_ah = HEX_EN ? 7'h7C : 7'h00;
            4'hC: w_pattern_ah = HEX_EN ? 7'h39 : 7'h00;
            4'hD: w_pattern_ah = HEX_EN ? 7'h5E : 7'h00;
            4'hE: w_pattern_ah = HEX_EN ? 7'h79 : 7'h00;
            4'hF: w_pattern_ah = HEX_EN ? 7'h71 : 7'h00;
            default: w_pattern_ah = 7'h00;
        endcase
    end

    assign w_pattern = ACTIVE_LOW ? ~w_pattern_ah : w_pattern_ah;

    always_ff @(posedge clock) begin
        if (reset)
            r_seg_q <= SEG_OFF;
        else if (lamp_test)
            r_seg_q <= SEG_ON;
        else if (blank)
            r_seg_q <= SEG_OFF;
        else
            r_seg_q <= w_pattern;
    end

    assign seg = r_seg_q;

endmodule

// File: tb/tb_seg7_digit_decoder.sv
// Bench for seg7_digit_decoder: default and (ACTIVE_LOW=0, HEX_EN=0) variants
// plus six default instances standing in for an hh:mm:ss timer.
module tb_seg7_digit_decoder;

    logic             clock = 1'b0;
    logic             reset, blank, lamp_test;
    logic [3:0]       digit;
    logic [6:0]       seg_d, seg_v;
    logic [5:0][3:0]  tdig;
    logic [5:0][6:0]  tseg;

    int vectors     = 0;
    int miscompares = 0;

    // Lit segments per digit, by segment letter.
    string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    always #5 clock = ~clock;

    seg7_digit_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_d (
        .clock(clock), .reset(reset), .digit(digit), .blank(blank),
        .lamp_test(lamp_test), .seg(seg_d));

    seg7_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_v (
        .clock(clock), .reset(reset), .digit(digit), .blank(blank),
        .lamp_test(lamp_test), .seg(seg_v));

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_timer
            seg7_digit_decoder u_dig (
                .clock(clock), .reset(reset), .digit(tdig[g]), .blank(blank),
                .lamp_test(lamp_test), .seg(tseg[g]));
        end
    endgenerate

    function automatic logic [6:0] model(int d, bit bl, bit lt, bit rst, bit al, bit hx);
        logic [6:0] on;
        string s;
        on = 7'h00;
        if (rst)          on = 7'h00;
        else if (lt)      on = 7'h7F;
        else if (bl)      on = 7'h00;
        else if (d < 10 || hx) begin
            s = LIT[d];
            for (int i = 0; i < s.len(); i++) on[int'(s[i]) - 97] = 1'b1;
        end
        return al ? ~on : on;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; digit = 4'd8; lamp_test = 1'b1; blank = 1'b0; tdig = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (seg_d !== 7'h7F) begin
                miscompares++;
                $display("FAIL reset_hold_d cyc%0d: got %h want 7f", c, seg_d);
            end
            vectors++;
            if (seg_v !== 7'h00) begin
                miscompares++;
                $display("FAIL reset_hold_v cyc%0d: got %h want 00", c, seg_v);
            end
        end
        reset = 1'b0;
        #2;
        vectors++;
        if (seg_d !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_release_pre: got %h want 7f", seg_d);
        end
        tick();
        vectors++;
        if (seg_d !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_release_post: got %h want 00", seg_d);
        end
        lamp_test = 1'b0;
    endtask

    task automatic test_sweep();
        logic [6:0] want [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        blank = 1'b0; lamp_test = 1'b0;
        for (int d = 0; d < 16; d++) begin
            digit = 4'(d);
            tick();
            vectors++;
            if (seg_d !== want[d] || seg_d !== model(d, 0, 0, 0, 1, 1)) begin
                miscompares++;
                $display("FAIL sweep_d digit%0d: got %h want %h", d, seg_d, want[d]);
            end
            vectors++;
            if (seg_v !== model(d, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL sweep_v digit%0d: got %h want %h", d, seg_v, model(d, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_overrides();
        digit = 4'd5; blank = 1'b1; lamp_test = 1'b0;
        tick();
        vectors++;
        if (seg_d !== 7'h7F) begin
            miscompares++;
            $display("FAIL blank: got %h want 7f", seg_d);
        end
        lamp_test = 1'b1;
        tick();
        vectors++;
        if (seg_d !== 7'h00) begin
            miscompares++;
            $display("FAIL lamp_over_blank: got %h want 00", seg_d);
        end
        blank = 1'b0; lamp_test = 1'b0;
        #2;
        vectors++;
        if (seg_d !== 7'h00) begin
            miscompares++;
            $display("FAIL override_hold: got %h want 00", seg_d);
        end
        tick();
        vectors++;
        if (seg_d !== 7'h12) begin
            miscompares++;
            $display("FAIL override_drop: got %h want 12", seg_d);
        end
    endtask

    task automatic test_latency();
        digit = 4'd3;
        tick();
        vectors++;
        if (seg_d !== 7'h30) begin
            miscompares++;
            $display("FAIL latency_3: got %h want 30", seg_d);
        end
        digit = 4'd4;
        #2;
        vectors++;
        if (seg_d !== 7'h30) begin
            miscompares++;
            $display("FAIL latency_hold: got %h want 30", seg_d);
        end
        tick();
        vectors++;
        if (seg_d !== 7'h19) begin
            miscompares++;
            $display("FAIL latency_4: got %h want 19", seg_d);
        end
    endtask

    task automatic test_variant();
        digit = 4'd2;
        tick();
        vectors++;
        if (seg_v !== 7'h5B) begin
            miscompares++;
            $display("FAIL variant_2: got %h want 5b", seg_v);
        end
        digit = 4'd12;
        tick();
        vectors++;
        if (seg_v !== 7'h00) begin
            miscompares++;
            $display("FAIL variant_12: got %h want 00", seg_v);
        end
        digit = 4'd8; reset = 1'b1;
        tick();
        vectors++;
        if (seg_v !== 7'h00) begin
            miscompares++;
            $display("FAIL variant_reset: got %h want 00", seg_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_timer();
        blank = 1'b0; lamp_test = 1'b0;
        for (int i = 0; i < 6; i++) tdig[i] = 4'd8;
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (tseg[i] !== 7'h00) begin
                miscompares++;
                $display("FAIL timer_finish dig%0d: got %h want 00", i, tseg[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int c = 0; c < 300; c++) begin
            digit     = 4'($urandom_range(0, 15));
            blank     = ($urandom_range(0, 3) == 0);
            lamp_test = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 6; i++) tdig[i] = 4'($urandom_range(0, 9));
            tick();
            e = model(digit, blank, lamp_test, reset, 1, 1);
            vectors++;
            if (seg_d !== e) begin
                miscompares++;
                $display("FAIL rand_d c%0d d%0d b%0b l%0b r%0b: got %h want %h",
                         c, digit, blank, lamp_test, reset, seg_d, e);
            end
            e = model(digit, blank, lamp_test, reset, 0, 0);
            vectors++;
            if (seg_v !== e) begin
                miscompares++;
                $display("FAIL rand_v c%0d d%0d b%0b l%0b r%0b: got %h want %h",
                         c, digit, blank, lamp_test, reset, seg_v, e);
            end
            for (int i = 0; i < 6; i++) begin
                e = model(tdig[i], blank, lamp_test, reset, 1, 1);
                vectors++;
                if (tseg[i] !== e) begin
                    miscompares++;
                    $display("FAIL rand_timer c%0d dig%0d: got %h want %h", c, i, tseg[i], e);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_overrides();
        test_latency();
        test_variant();
        test_timer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
